// File: rtl/afpm_pkg.sv
// Shared definitions for the logarithmic FP16 multiplier host driver.
package afpm_pkg;

    localparam int AFPM_BYTE_W    = 8;
    localparam int AFPM_WORD_W    = 16;
    localparam int AFPM_NUM_BYTES = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND_LO = 3'd1,
        S_SEND_HI = 3'd2,
        S_WAIT    = 3'd3,
        S_CAP_LO  = 3'd4,
        S_CAP_HI  = 3'd5,
        S_RESP    = 3'd6
    } afpm_drv_state_t;

    // Byte idx (0 = least significant) of a 16-bit word.
    function automatic logic [AFPM_BYTE_W-1:0] afpm_byte(
        input logic [AFPM_WORD_W-1:0] word,
        input int unsigned            idx
    );
        return word[idx*AFPM_BYTE_W +: AFPM_BYTE_W];
    endfunction

endpackage

// File: rtl/afpm_lat_counter.sv
// Loadable down-counter that times the tile pipeline latency.
// done is high whenever the count has reached zero.
module afpm_lat_counter
    import afpm_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load takes priority over decrement; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/afpm_host_driver.sv
// Host-side initiator for the logarithmic FP16 multiplier tile.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a request; lanes 0x00, last product held
// S_SEND_LO | operand low bytes on ui_drv / uio_drv
// S_SEND_HI | operand high bytes on ui_drv / uio_drv
// S_WAIT    | LATENCY-1 cycles for the tile pipeline (skipped if LATENCY=1)
// S_CAP_LO  | uo_in sampled into rsp_data[7:0] at the end of this cycle
// S_CAP_HI  | uo_in sampled into rsp_data[15:8] at the end of this cycle
// S_RESP    | rsp_valid high until the response handshake
module afpm_host_driver
    import afpm_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AFPM_WORD_W-1:0] req_a,
    input  logic [AFPM_WORD_W-1:0] req_b,
    output logic [AFPM_BYTE_W-1:0] ui_drv,
    output logic [AFPM_BYTE_W-1:0] uio_drv,
    input  logic [AFPM_BYTE_W-1:0] uo_in,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [AFPM_WORD_W-1:0] rsp_data,
    output logic                   busy,
    output logic [7:0]             txn_count
);

    localparam int CNT_W = $clog2(LATENCY + 1);
    // The counter is loaded on the way into S_WAIT and S_WAIT exits when it
    // reads zero, so loading LATENCY-2 gives LATENCY-1 wait cycles.
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

    afpm_drv_state_t        state;
    // Low operand bytes go to the lanes directly at acceptance, so only the
    // high bytes have to be held for the following cycle.
    logic [AFPM_BYTE_W-1:0] op_a_hi;
    logic [AFPM_BYTE_W-1:0] op_b_hi;
    logic                   cnt_load;
    logic                   cnt_dec;
    logic                   cnt_done;

    // Counter control decoded from the current state.
    always_comb begin
        cnt_load = (state == S_SEND_HI);
        cnt_dec  = (state == S_WAIT) && !cnt_done;
    end

    afpm_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .done     (cnt_done)
    );

    // Sequencing FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            ui_drv    <= '0;
            uio_drv   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            txn_count <= '0;
            op_a_hi   <= '0;
            op_b_hi   <= '0;
        end else begin
            ui_drv  <= '0;
            uio_drv <= '0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_a_hi   <= afpm_byte(req_a, 1);
                        op_b_hi   <= afpm_byte(req_b, 1);
                        ui_drv    <= afpm_byte(req_a, 0);
                        uio_drv   <= afpm_byte(req_b, 0);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SEND_LO;
                    end
                end
                S_SEND_LO: begin
                    ui_drv  <= op_a_hi;
                    uio_drv <= op_b_hi;
                    state   <= S_SEND_HI;
                end
                S_SEND_HI: begin
                    if (LATENCY == 1) begin
                        state <= S_CAP_LO;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_done) begin
                        state <= S_CAP_LO;
                    end
                end
                S_CAP_LO: begin
                    rsp_data[AFPM_BYTE_W-1:0] <= uo_in;
                    state                     <= S_CAP_HI;
                end
                S_CAP_HI: begin
                    rsp_data[AFPM_WORD_W-1:AFPM_BYTE_W] <= uo_in;
                    rsp_valid                           <= 1'b1;
                    state                               <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        txn_count <= txn_count + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_afpm_host_driver.sv
// Directed bench for afpm_host_driver: LATENCY=3 and LATENCY=1 instances
// share stimulus; sel picks which one is exercised and observed.
module tb_afpm_host_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_a, req_b;
    logic [7:0]  uo_in;
    logic        rsp_ready;
    logic        sel;

    logic        rr3, busy3, rv3, rr1, busy1, rv1;
    logic [7:0]  ui3, uio3, tc3, ui1, uio1, tc1;
    logic [15:0] rd3, rd1;

    logic        cur_rr, cur_busy, cur_rv;
    logic [7:0]  cur_ui, cur_uio, cur_tc;
    logic [15:0] cur_rd;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_acc = 0;
    logic [7:0]  exp_tc3 = 8'd0;
    logic [7:0]  exp_tc1 = 8'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    afpm_host_driver #(.LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_ready(rr3),
        .req_a(req_a), .req_b(req_b), .ui_drv(ui3), .uio_drv(uio3), .uo_in(uo_in),
        .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_data(rd3), .busy(busy3),
        .txn_count(tc3)
    );

    afpm_host_driver #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_ready(rr1),
        .req_a(req_a), .req_b(req_b), .ui_drv(ui1), .uio_drv(uio1), .uo_in(uo_in),
        .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_data(rd1), .busy(busy1),
        .txn_count(tc1)
    );

    assign cur_rr   = sel ? rr1   : rr3;
    assign cur_busy = sel ? busy1 : busy3;
    assign cur_rv   = sel ? rv1   : rv3;
    assign cur_ui   = sel ? ui1   : ui3;
    assign cur_uio  = sel ? uio1  : uio3;
    assign cur_tc   = sel ? tc1   : tc3;
    assign cur_rd   = sel ? rd1   : rd3;

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        int          stall;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Arbitrary tile response used for the random run.
    function automatic logic [15:0] tile_fn(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] lo, hi;
        lo = a[7:0] ^ b[15:8];
        hi = a[15:8] + b[7:0];
        return {hi, lo};
    endfunction

    // One full transaction; entered and left at a negedge with the DUT idle.
    task automatic run_txn(input logic s, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] r, input int stall, input bit tp);
        int lat;
        int acc;
        lat = s ? 1 : 3;
        sel = s;
        #1;
        chk("idle_req_ready", 32'(cur_rr), 32'd1);
        chk("idle_busy", 32'(cur_busy), 32'd0);
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        acc = cyc;
        if (tp) chk("throughput", 32'(acc - last_acc), 32'(5 + lat));
        last_acc = acc;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = ~a;
        req_b = ~b;
        chk("send_lo_ui", 32'(cur_ui), 32'(a[7:0]));
        chk("send_lo_uio", 32'(cur_uio), 32'(b[7:0]));
        chk("send_lo_busy", 32'(cur_busy), 32'd1);
        chk("send_lo_req_ready", 32'(cur_rr), 32'd0);
        @(negedge clk);
        chk("send_hi_ui", 32'(cur_ui), 32'(a[15:8]));
        chk("send_hi_uio", 32'(cur_uio), 32'(b[15:8]));
        for (int k = 3; k <= lat + 1; k++) begin
            @(negedge clk);
            chk("wait_lanes", 32'({cur_ui, cur_uio}), 32'd0);
            chk("wait_rsp_valid", 32'(cur_rv), 32'd0);
        end
        @(negedge clk);
        uo_in = r[7:0];
        chk("cap_lo_lanes", 32'({cur_ui, cur_uio}), 32'd0);
        @(negedge clk);
        uo_in = r[15:8];
        chk("cap_hi_rsp_valid", 32'(cur_rv), 32'd0);
        @(negedge clk);
        uo_in = 8'hEE;
        chk("resp_valid", 32'(cur_rv), 32'd1);
        chk("resp_data", 32'(cur_rd), 32'(r));
        chk("resp_lanes", 32'({cur_ui, cur_uio}), 32'd0);
        for (int i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(cur_rv), 32'd1);
            chk("stall_data", 32'(cur_rd), 32'(r));
            chk("stall_req_ready", 32'(cur_rr), 32'd0);
            req_valid = (i == 2);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        chk("handshake_valid", 32'(cur_rv), 32'd1);
        @(negedge clk);
        if (s) exp_tc1 = exp_tc1 + 8'd1;
        else   exp_tc3 = exp_tc3 + 8'd1;
        chk("done_rsp_valid", 32'(cur_rv), 32'd0);
        chk("done_req_ready", 32'(cur_rr), 32'd1);
        chk("done_busy", 32'(cur_busy), 32'd0);
        chk("done_lanes", 32'({cur_ui, cur_uio}), 32'd0);
        chk("done_data_hold", 32'(cur_rd), 32'(r));
        chk("txn_count", 32'(cur_tc), 32'(s ? exp_tc1 : exp_tc3));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;

        vecs[0] = '{1'b0, 16'h44DF, 16'h483D, 16'h1234, 0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 16'hABCD, 5};
        vecs[2] = '{1'b1, 16'h0101, 16'h0101, 16'h0201, 0};
        vecs[3] = '{1'b1, 16'h8000, 16'h7FFF, 16'h00FF, 2};
        vecs[4] = '{1'b0, 16'hA55A, 16'h5AA5, 16'h0000, 1};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 16'hFFFF, 0};

        rst_n = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        uo_in = '0;
        rsp_ready = 1'b1;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'({rr3, rr1}), 32'h3);
        chk("rst_busy", 32'({busy3, busy1}), 32'h0);
        chk("rst_lanes", 32'({ui3, uio3}), 32'h0);
        chk("rst_rsp_valid", 32'(rv3), 32'd0);
        chk("rst_rsp_data", 32'(rd3), 32'd0);
        chk("rst_txn_count", 32'(tc3), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_txn(vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].r, vecs[v].stall, 1'b0);
            @(negedge clk);
        end

        // Reset in the middle of WAIT on the LATENCY=3 instance.
        sel = 1'b0;
        req_a = 16'h1357;
        req_b = 16'h2468;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wait_busy", 32'(busy3), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'({rr3, rr1}), 32'h3);
        chk("mid_rst_busy", 32'({busy3, busy1}), 32'h0);
        chk("mid_rst_lanes", 32'({ui3, uio3}), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rv3), 32'd0);
        chk("mid_rst_rsp_data", 32'({rd3, rd1}), 32'h0);
        chk("mid_rst_txn_count", 32'({tc3, tc1}), 32'h0);
        exp_tc3 = 8'd0;
        exp_tc1 = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 256 back-to-back transactions: txn_count returns to 0.
        for (int n = 0; n < 256; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_txn(1'b0, ra, rb, tile_fn(ra, rb), 0, n > 0);
        end
        chk("wrap_txn_count", 32'(tc3), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
